// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared types and frame geometry for the frame sequencer
package frame_seq_pkg;

    localparam int STATE_W       = 64;
    localparam int ROWS          = 28;
    localparam int COLS          = 28;
    localparam int PIX_W         = ROWS * COLS;
    localparam int SETTLE_CYCLES = 2;
    localparam int ROW_IDX_W     = 5;

    typedef logic [ROW_IDX_W-1:0] row_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_STREAM,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/frame_row_buffer.sv
// rtl/frame_row_buffer.sv - frame capture register with row-select read mux
module frame_row_buffer
    import frame_seq_pkg::*;
#(
    parameter int ROWS = frame_seq_pkg::ROWS,
    parameter int COLS = frame_seq_pkg::COLS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture_en,
    input  logic [ROWS*COLS-1:0] pixels,
    input  row_idx_t             row_idx,
    output logic [COLS-1:0]      row_data
);

    logic [ROWS*COLS-1:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (capture_en) begin
            frame_q <= pixels;
        end
    end

    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx == row_idx_t'(r)) begin
                row_data = frame_q[r*COLS +: COLS];
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - state feedback, settle, capture and row streaming controller
module frame_sequencer #(
    parameter int STATE_W       = frame_seq_pkg::STATE_W,
    parameter int ROWS          = frame_seq_pkg::ROWS,
    parameter int COLS          = frame_seq_pkg::COLS,
    parameter int SETTLE_CYCLES = frame_seq_pkg::SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_i,
    input  logic                 step_i,
    input  logic                 load_i,
    input  logic [STATE_W-1:0]   load_state_i,
    output logic [STATE_W-1:0]   state_o,
    input  logic [ROWS*COLS-1:0] pixels_i,
    output logic                 row_valid_o,
    input  logic                 row_ready_i,
    output logic [COLS-1:0]      row_data_o,
    output logic [4:0]           row_idx_o,
    output logic                 frame_done_o,
    output logic                 busy_o,
    output logic                 load_err_o,
    output logic [31:0]          frame_count_o
);

    import frame_seq_pkg::*;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_t       state_q;
    logic [CNT_W-1:0] settle_cnt;
    row_idx_t         row_idx_q;

    assign row_idx_o = row_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            settle_cnt    <= '0;
            row_idx_q     <= '0;
            state_o       <= '0;
            row_valid_o   <= 1'b0;
            frame_done_o  <= 1'b0;
            busy_o        <= 1'b0;
            load_err_o    <= 1'b0;
            frame_count_o <= '0;
        end else begin
            frame_done_o <= 1'b0;
            load_err_o   <= load_i && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    // A load consumes the cycle; a start request alongside it is dropped.
                    if (load_i) begin
                        state_o <= load_state_i;
                    end else if (run_i || step_i) begin
                        state_q    <= ST_SETTLE;
                        settle_cnt <= '0;
                        busy_o     <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state_o     <= pixels_i[STATE_W-1:0];
                    state_q     <= ST_STREAM;
                    row_idx_q   <= '0;
                    row_valid_o <= 1'b1;
                end
                ST_STREAM: begin
                    if (row_ready_i) begin
                        if (row_idx_q == row_idx_t'(ROWS - 1)) begin
                            state_q       <= ST_DONE;
                            row_valid_o   <= 1'b0;
                            row_idx_q     <= '0;
                            frame_done_o  <= 1'b1;
                            frame_count_o <= frame_count_o + 32'd1;
                        end else begin
                            row_idx_q <= row_idx_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (run_i) begin
                        state_q    <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_o      <= 1'b0;
                    row_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Buffer is only written in CAPTURE, so new state_o cannot disturb a frame in flight.
    frame_row_buffer #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_row_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_en(state_q == ST_CAPTURE),
        .pixels    (pixels_i),
        .row_idx   (row_idx_q),
        .row_data  (row_data_o)
    );

endmodule
